// File: rtl/bus_xfer_decoder.sv
// Queued register-transfer decoder: expands {src,dst} codes into one-hot bus-drive and load strobes.
// Optional range checking of codes against MAX_CODE is compiled in with `define BUSDEC_RANGE_CHECK_EN.
module bus_xfer_decoder #(
    parameter int DEPTH    = 4,
    parameter int HOLD     = 1,
    parameter int MAX_CODE = 24
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_src,
    input  logic [4:0]               req_dst,
    output logic [31:0]              src_out,
    output logic [31:0]              dst_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0]    HOLD_M1 = 4'(HOLD - 1);
    localparam logic [5:0]    MAXC    = 6'(MAX_CODE);
    localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);
`ifdef BUSDEC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH} state_t;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_run;

    state_t        r_state;
    logic [3:0]    r_hold_cnt;
    logic [4:0]    r_cur_dst;
    logic [31:0]   r_src_out;
    logic [31:0]   r_dst_in;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [4:0]    w_head_src;
    logic [4:0]    w_head_dst;
    logic          w_head_bad;

    function automatic logic [31:0] onehot(input logic [4:0] code);
        return 32'd1 << code;
    endfunction

    assign w_nonempty = (r_level != '0);
    assign req_ready  = r_run && (r_level != FULL_LV);
    assign w_push     = req_valid && req_ready;
    assign w_head_src = r_mem[r_rd_ptr][9:5];
    assign w_head_dst = r_mem[r_rd_ptr][4:0];
    assign w_head_bad = RANGE_EN && (({1'b0, w_head_src} >= MAXC) || ({1'b0, w_head_dst} >= MAXC));

    // A good entry waiting behind LATCH is chained straight into DRIVE; a bad one is left for IDLE to reject,
    // so its err pulse never coincides with the done pulse of the transfer ahead of it.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_nonempty;
            S_LATCH: w_pop = w_nonempty && !w_head_bad;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= {req_src, req_dst};
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Outputs are registered with the state they belong to, so they appear in the same cycle as that state.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_cur_dst  <= '0;
            r_src_out  <= '0;
            r_dst_in   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_nonempty) begin
                        if (w_head_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cur_dst  <= w_head_dst;
                            r_hold_cnt <= HOLD_M1;
                            r_src_out  <= onehot(w_head_src);
                            r_busy     <= 1'b1;
                            r_state    <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_dst_in <= onehot(r_cur_dst);
                        r_state  <= S_LATCH;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                S_LATCH: begin
                    r_done   <= 1'b1;
                    r_dst_in <= '0;
                    if (w_pop) begin
                        r_cur_dst  <= w_head_dst;
                        r_hold_cnt <= HOLD_M1;
                        r_src_out  <= onehot(w_head_src);
                        r_state    <= S_DRIVE;
                    end else begin
                        r_src_out <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign src_out = r_src_out;
    assign dst_in  = r_dst_in;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = RANGE_EN ? r_err : 1'b0;
    assign level   = r_level;

endmodule

// File: doc/bus_xfer_decoder.md
# bus_xfer_decoder

Sequenced register-transfer decoder for the CPU's shared 32-bit bus: the inverse of the bus encoder path. It queues transfer requests as 5-bit source/destination register codes and expands each into one-hot source-drive selects (feeding the bus encoder/mux) and one-hot destination load enables, with a fixed drive-then-latch sequence. It sits between the control unit and the register file/bus mux, so the control unit can post several transfers back-to-back.

## Interface
- DEPTH, 4, request queue depth; power of 2, at least 2
- HOLD, 1, cycles the source is driven before the latch cycle; 1..15
- MAX_CODE, 24, first illegal register code; used only when range checking is compiled in
- clock  in  1  system clock, rising edge
- clear  in  1  reset, asynchronous, active-low
- req_valid  in  1  transfer request present
- req_ready  out  1  queue can accept; equals !full
- req_src  in  5  source register code
- req_dst  in  5  destination register code
- src_out  out  32  one-hot bus-drive select, bit n = register n drives the bus
- dst_in  out  32  one-hot load enable, bit n = register n latches the bus
- busy  out  1  high in DRIVE or LATCH
- done  out  1  one-cycle pulse per completed transfer
- err  out  1  one-cycle pulse per rejected request
- level  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Queue: FIFO of {src,dst}, DEPTH entries, with wrapping read and write pointers. A push occurs on req_valid && req_ready. A pop is performed only by the FSM.
  - Push and pop in the same cycle: both take effect; level is unchanged.
  - Push while full is impossible because req_ready is low.
- FSM states: IDLE, DRIVE, LATCH.
- IDLE:
  - If level > 0: pop into cur_src/cur_dst, load hold_cnt = HOLD-1, and go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE:
  - src_out = 1<<cur_src; dst_in = 0.
  - If hold_cnt == 0, go to LATCH; otherwise decrement hold_cnt.
- LATCH:
  - src_out = 1<<cur_src; dst_in = 1<<cur_dst.
  - Next state is DRIVE with a fresh pop if level > 0; otherwise IDLE.
  - In both cases, done = 1 in the following cycle.
- src_out, dst_in, busy and done are flop outputs, so they are glitch-free and at most one bit is set per vector.
- src == dst is legal: that register both drives and loads in LATCH.
- Newly pushed entries are never bypassed to the FSM; every entry passes through the queue.
- Reset (clear low, at any time): queue flushed, level = 0, FSM = IDLE, and src_out, dst_in, busy, done, err = 0. req_ready goes to 1 once out of reset. An in-flight transfer is abandoned without a done pulse.

## Timing
- Cycle 0: request accepted at the end of cycle 0, with the queue empty and the FSM idle.
- Cycle 1: FSM pops.
- Cycles 2..HOLD+1: DRIVE.
- Cycle HOLD+2: LATCH.
- Cycle HOLD+3: done = 1.
- Back-to-back throughput is one transfer per HOLD+1 cycles. LATCH goes directly to DRIVE when the queue is non-empty.
- level updates in the cycle after the push or pop edge.
- done and err never assert in the same cycle.

## Configuration
- BUSDEC_RANGE_CHECK_EN defined:
  - At pop, an entry with src ≥ MAX_CODE or dst ≥ MAX_CODE is discarded.
  - err pulses for one cycle and the FSM stays in IDLE; the next entry, if any, pops in the following cycle.
  - No bus activity occurs and done is not pulsed for a rejected entry.
- BUSDEC_RANGE_CHECK_EN undefined:
  - All 32 codes are decoded normally.
  - err is tied to 0.

## Test plan
- Reset and single transfer: assert clear low, release, push src=3 dst=7 with HOLD=1. Required response:
  - src_out = 0x00000008 in cycle 2.
  - Cycle 3: src_out = 0x00000008, dst_in = 0x00000080.
  - done pulses in cycle 4.
  - All outputs are 0 during reset.
- Back-to-back: push (1→2), (4→5), (31→0) on consecutive cycles with HOLD=2. Required response:
  - Three LATCH cycles spaced 3 cycles apart, with dst_in = 0x4, 0x20, 0x1.
  - Exactly three done pulses.
  - busy stays high throughout.
- Full queue: hold the FSM busy with HOLD=15 and push 1+DEPTH requests. Required response:
  - req_ready drops when level = DEPTH.
  - A push with req_ready low is ignored, i.e. the extra request is dropped.
  - Push and pop in the same cycle keep level constant.
- Reset mid-DRIVE: pull clear low during DRIVE. Required response:
  - src_out, dst_in, busy and level go to 0 immediately.
  - No done pulse.
  - A new request after release completes normally.
- Range check (macro defined, MAX_CODE=24): push (25→1) then (2→3). Required response:
  - err pulses once with no src_out activity for the first request.
  - The second transfer completes with dst_in = 0x8.
- Same test with the macro undefined. Required response:
  - The first transfer is driven, with src_out = 0x02000000.
  - err stays 0.
